// File: rtl/instr_fetch_mem.sv
// instr_fetch_mem
//   Pipelined instruction memory sitting between fetch/PC logic and the
//   decoder. It takes valid/ready fetch requests, answers them RD_LAT cycles
//   later through a response queue that absorbs consumer backpressure, drops
//   everything in flight on a flush, and has a program-load write port.
//
//   Ports
//     i_clk / i_rst_n        clock, asynchronous active-low reset
//     i_req_valid/o_req_ready/i_req_addr   fetch request
//     o_rsp_valid/i_rsp_ready/o_rsp_instr/o_rsp_err   fetch response
//     i_flush                discard all in-flight and queued responses
//     i_wr_en/i_wr_addr/i_wr_data          program-load write
//
//   Structure
//     The memory is read at the accept edge. RD_LAT-1 delay stages follow,
//     and the last stage writes straight into the response queue, so a
//     response becomes visible RD_LAT cycles after its request cycle. The
//     delay stages never stall: the credit counter bounds in-flight plus
//     queued entries to the queue depth, so the queue always has room.
module instr_fetch_mem #(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 8,
    parameter int                DEPTH     = 256,
    parameter int                RD_LAT    = 1,
    parameter logic [DATA_W-1:0] ERR_INSTR = '0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [ADDR_W-1:0] i_req_addr,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_instr,
    output logic              o_rsp_err,
    input  logic              i_flush,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data
);

    localparam int CAP = RD_LAT + 1;
    localparam int CW  = $clog2(CAP + 1);
    localparam int PW  = $clog2(CAP);
    localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_wr_in;
    logic              w_rd_in;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_rd_err;
    logic              w_acc;
    logic              w_pop;
    logic              w_push;
    logic [DATA_W-1:0] w_push_data;
    logic              w_push_err;

    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     r_q_cnt;
    logic [PW-1:0]     r_rd_ptr;
    logic [PW-1:0]     r_wr_ptr;
    logic [DATA_W-1:0] r_q_data [CAP];
    logic [CAP-1:0]    r_q_err;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (32'(p) == CAP - 1) ? '0 : p + 1'b1;
    endfunction

    assign w_wr_in = i_wr_en && (32'(i_wr_addr) < DEPTH);
    assign w_rd_in = 32'(i_req_addr) < DEPTH;

    always_ff @(posedge i_clk) begin
        if (w_wr_in) begin
            r_mem[i_wr_addr[IW-1:0]] <= i_wr_data;
        end
    end

    // Write-first: a read of the address being written this edge sees the new data.
    always_comb begin
        w_rd_err  = !w_rd_in;
        w_rd_data = ERR_INSTR;
        if (w_rd_in) begin
            if (w_wr_in && (i_wr_addr == i_req_addr)) begin
                w_rd_data = i_wr_data;
            end else begin
                w_rd_data = r_mem[i_req_addr[IW-1:0]];
            end
        end
    end

    assign o_rsp_valid = (r_q_cnt != '0);
    assign o_rsp_instr = o_rsp_valid ? r_q_data[r_rd_ptr] : '0;
    assign o_rsp_err   = o_rsp_valid && r_q_err[r_rd_ptr];

    assign w_pop = o_rsp_valid && i_rsp_ready;

    // A pop or a flush frees credit in the same cycle, so either lets a
    // request in even when every slot is taken.
    assign o_req_ready = (32'(r_cnt) < CAP) || w_pop || i_flush;
    assign w_acc       = i_req_valid && o_req_ready;

    generate
        if (RD_LAT == 1) begin : g_nodly
            assign w_push      = w_acc;
            assign w_push_data = w_rd_data;
            assign w_push_err  = w_rd_err;
        end else begin : g_dly
            logic [RD_LAT-2:0] r_s_vld;
            logic [RD_LAT-2:0] r_s_err;
            logic [DATA_W-1:0] r_s_data [RD_LAT-1];

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_s_vld <= '0;
                    r_s_err <= '0;
                    for (int i = 0; i < RD_LAT - 1; i++) begin
                        r_s_data[i] <= '0;
                    end
                end else begin
                    // The request accepted alongside a flush survives it.
                    r_s_vld[0]  <= w_acc;
                    r_s_data[0] <= w_rd_data;
                    r_s_err[0]  <= w_rd_err;
                    for (int i = 1; i < RD_LAT - 1; i++) begin
                        r_s_vld[i]  <= r_s_vld[i-1] && !i_flush;
                        r_s_data[i] <= r_s_data[i-1];
                        r_s_err[i]  <= r_s_err[i-1];
                    end
                end
            end

            assign w_push      = r_s_vld[RD_LAT-2] && !i_flush;
            assign w_push_data = r_s_data[RD_LAT-2];
            assign w_push_err  = r_s_err[RD_LAT-2];
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt    <= '0;
            r_q_cnt  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_q_err  <= '0;
            for (int i = 0; i < CAP; i++) begin
                r_q_data[i] <= '0;
            end
        end else begin
            if (i_flush) begin
                r_cnt    <= CW'(w_acc);
                r_q_cnt  <= CW'(w_push);
                r_rd_ptr <= r_wr_ptr;
            end else begin
                r_cnt   <= r_cnt + CW'(w_acc) - CW'(w_pop);
                r_q_cnt <= r_q_cnt + CW'(w_push) - CW'(w_pop);
                if (w_pop) begin
                    r_rd_ptr <= f_inc(r_rd_ptr);
                end
            end
            if (w_push) begin
                r_q_data[r_wr_ptr] <= w_push_data;
                r_q_err[r_wr_ptr]  <= w_push_err;
                r_wr_ptr           <= f_inc(r_wr_ptr);
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_mem.sv
module tb_instr_fetch_mem;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid [3];
    logic        req_ready [3];
    logic [7:0]  req_addr  [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [15:0] rsp_instr [3];
    logic        rsp_err   [3];
    logic        flush     [3];
    logic        wr_en     [3];
    logic [7:0]  wr_addr   [3];
    logic [15:0] wr_data   [3];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [16:0] exp_q   [3][$];
    int          pop_cyc [3][$];
    int          acc_cyc [3][$];
    logic [15:0] mdl     [3][256];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    instr_fetch_mem #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .RD_LAT(1), .ERR_INSTR(16'h0000)) u_lat1 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]), .i_req_addr(req_addr[0]),
        .o_rsp_valid(rsp_valid[0]), .i_rsp_ready(rsp_ready[0]), .o_rsp_instr(rsp_instr[0]),
        .o_rsp_err(rsp_err[0]), .i_flush(flush[0]),
        .i_wr_en(wr_en[0]), .i_wr_addr(wr_addr[0]), .i_wr_data(wr_data[0]));

    instr_fetch_mem #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .RD_LAT(3), .ERR_INSTR(16'h0000)) u_lat3 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]), .i_req_addr(req_addr[1]),
        .o_rsp_valid(rsp_valid[1]), .i_rsp_ready(rsp_ready[1]), .o_rsp_instr(rsp_instr[1]),
        .o_rsp_err(rsp_err[1]), .i_flush(flush[1]),
        .i_wr_en(wr_en[1]), .i_wr_addr(wr_addr[1]), .i_wr_data(wr_data[1]));

    instr_fetch_mem #(.DATA_W(16), .ADDR_W(8), .DEPTH(200), .RD_LAT(2), .ERR_INSTR(16'hDEAD)) u_lat2 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid[2]), .o_req_ready(req_ready[2]), .i_req_addr(req_addr[2]),
        .o_rsp_valid(rsp_valid[2]), .i_rsp_ready(rsp_ready[2]), .o_rsp_instr(rsp_instr[2]),
        .o_rsp_err(rsp_err[2]), .i_flush(flush[2]),
        .i_wr_en(wr_en[2]), .i_wr_addr(wr_addr[2]), .i_wr_data(wr_data[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard per instance: expected {err, instr} pushed on accept,
    // popped and compared on each response handshake.
    for (genvar k = 0; k < 3; k++) begin : g_mon
        localparam int          D  = (k == 2) ? 200 : 256;
        localparam logic [15:0] EV = (k == 2) ? 16'hDEAD : 16'h0000;
        logic        hv = 1'b0;
        logic [15:0] hd;
        logic [16:0] e;

        always @(negedge clk) begin
            if (!rst_n) begin
                exp_q[k].delete();
                hv = 1'b0;
            end else begin
                if (hv) begin
                    chk($sformatf("hold%0d", k), 32'({rsp_valid[k], rsp_instr[k]}), 32'({1'b1, hd}));
                end
                hv = rsp_valid[k] && !rsp_ready[k] && !flush[k];
                hd = rsp_instr[k];
                if (flush[k]) begin
                    exp_q[k].delete();
                end else if (rsp_valid[k] && rsp_ready[k]) begin
                    pop_cyc[k].push_back(cyc);
                    if (exp_q[k].size() == 0) begin
                        chk($sformatf("sb_extra%0d", k), 32'({rsp_err[k], rsp_instr[k]}), 32'h1_FFFF);
                    end else begin
                        e = exp_q[k].pop_front();
                        chk($sformatf("sb_rsp%0d", k), 32'({rsp_err[k], rsp_instr[k]}), 32'(e));
                    end
                end
                if (req_valid[k] && req_ready[k]) begin
                    acc_cyc[k].push_back(cyc);
                    if (32'(req_addr[k]) >= D) e = {1'b1, EV};
                    else if (wr_en[k] && wr_addr[k] == req_addr[k]) e = {1'b0, wr_data[k]};
                    else e = {1'b0, mdl[k][req_addr[k]]};
                    exp_q[k].push_back(e);
                end
                if (wr_en[k] && 32'(wr_addr[k]) < D) mdl[k][wr_addr[k]] = wr_data[k];
            end
        end
    end

    typedef struct {
        logic        wr_en;
        logic [7:0]  wr_addr;
        logic [15:0] wr_data;
        logic        req_valid;
        logic [7:0]  req_addr;
        logic        rsp_ready;
        logic        flush;
        logic        e_valid;
        logic [15:0] e_instr;
        logic        e_err;
        logic        e_ready;
    } vec_t;

    function automatic vec_t mk(bit we, int wa, int wd, bit rv, int ra, bit rr, bit fl,
                                bit ev, int ei, bit ee, bit er);
        vec_t v;
        v.wr_en = we; v.wr_addr = 8'(wa); v.wr_data = 16'(wd);
        v.req_valid = rv; v.req_addr = 8'(ra); v.rsp_ready = rr; v.flush = fl;
        v.e_valid = ev; v.e_instr = 16'(ei); v.e_err = ee; v.e_ready = er;
        return v;
    endfunction

    initial begin
        vec_t tbl [21];
        int   pl  [8] = '{0, 1, 2, 3, 4, 8, 50, 122};
        int   a;

        // Cycle-accurate vectors for the RD_LAT=1 instance.
        tbl[0]  = mk(1, 0, 'h0000, 0, 0, 1, 0,  0, 0,       0, 1);
        tbl[1]  = mk(1, 1, 'h0101, 0, 0, 1, 0,  0, 0,       0, 1);
        tbl[2]  = mk(0, 0, 0,      1, 0, 1, 0,  0, 0,       0, 1);
        tbl[3]  = mk(0, 0, 0,      1, 1, 1, 0,  1, 'h0000,  0, 1);
        tbl[4]  = mk(0, 0, 0,      0, 0, 1, 0,  1, 'h0101,  0, 1);
        tbl[5]  = mk(0, 0, 0,      0, 0, 1, 0,  0, 0,       0, 1);
        tbl[6]  = mk(0, 0, 0,      1, 1, 0, 0,  0, 0,       0, 1);
        tbl[7]  = mk(0, 0, 0,      1, 0, 0, 0,  1, 'h0101,  0, 1);
        tbl[8]  = mk(0, 0, 0,      1, 1, 0, 0,  1, 'h0101,  0, 0);
        tbl[9]  = mk(0, 0, 0,      1, 1, 1, 0,  1, 'h0101,  0, 1);
        tbl[10] = mk(0, 0, 0,      0, 0, 1, 0,  1, 'h0000,  0, 1);
        tbl[11] = mk(0, 0, 0,      0, 0, 1, 0,  1, 'h0101,  0, 1);
        tbl[12] = mk(0, 0, 0,      0, 0, 1, 0,  0, 0,       0, 1);
        tbl[13] = mk(0, 0, 0,      1, 0, 0, 0,  0, 0,       0, 1);
        tbl[14] = mk(0, 0, 0,      1, 0, 0, 0,  1, 'h0000,  0, 1);
        tbl[15] = mk(0, 0, 0,      1, 1, 0, 1,  1, 'h0000,  0, 1);
        tbl[16] = mk(0, 0, 0,      0, 0, 1, 0,  1, 'h0101,  0, 1);
        tbl[17] = mk(0, 0, 0,      0, 0, 1, 0,  0, 0,       0, 1);
        tbl[18] = mk(1, 9, 'hBEEF, 1, 9, 1, 0,  0, 0,       0, 1);
        tbl[19] = mk(0, 0, 0,      0, 0, 1, 0,  1, 'hBEEF,  0, 1);
        tbl[20] = mk(0, 0, 0,      0, 0, 1, 0,  0, 0,       0, 1);

        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req_valid[k] = 1'b0; req_addr[k] = '0; rsp_ready[k] = 1'b1;
            flush[k] = 1'b0; wr_en[k] = 1'b0; wr_addr[k] = '0; wr_data[k] = '0;
        end

        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst_rsp_valid", 32'(rsp_valid[k]), 32'd0);
            chk("rst_rsp_err",   32'(rsp_err[k]),   32'd0);
            chk("rst_rsp_instr", 32'(rsp_instr[k]), 32'd0);
            chk("rst_req_ready", 32'(req_ready[k]), 32'd1);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        for (int i = 0; i < 21; i++) begin
            wr_en[0] = tbl[i].wr_en; wr_addr[0] = tbl[i].wr_addr; wr_data[0] = tbl[i].wr_data;
            req_valid[0] = tbl[i].req_valid; req_addr[0] = tbl[i].req_addr;
            rsp_ready[0] = tbl[i].rsp_ready; flush[0] = tbl[i].flush;
            @(negedge clk);
            chk($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid[0]), 32'(tbl[i].e_valid));
            chk($sformatf("v%0d_rsp_instr", i), 32'(rsp_instr[0]), 32'(tbl[i].e_instr));
            chk($sformatf("v%0d_rsp_err", i),   32'(rsp_err[0]),   32'(tbl[i].e_err));
            chk($sformatf("v%0d_req_ready", i), 32'(req_ready[0]), 32'(tbl[i].e_ready));
            tick();
        end
        req_valid[0] = 1'b0; wr_en[0] = 1'b0; flush[0] = 1'b0; rsp_ready[0] = 1'b1;

        // RD_LAT=3: eight back-to-back fetches, no bubbles.
        for (int i = 0; i < 8; i++) begin
            wr_en[1] = 1'b1; wr_addr[1] = 8'(i); wr_data[1] = 16'h1000 + 16'(i * 17);
            tick();
        end
        wr_en[1] = 1'b0;
        acc_cyc[1].delete(); pop_cyc[1].delete();
        for (int i = 0; i < 8; i++) begin
            req_valid[1] = 1'b1; req_addr[1] = 8'(i);
            tick();
        end
        req_valid[1] = 1'b0;
        for (int t = 0; t < 20 && pop_cyc[1].size() < 8; t++) tick();
        chk("lat3_accepts", 32'(acc_cyc[1].size()), 32'd8);
        chk("lat3_responses", 32'(pop_cyc[1].size()), 32'd8);
        if (acc_cyc[1].size() == 8 && pop_cyc[1].size() == 8) begin
            chk("lat3_first_latency", 32'(pop_cyc[1][0] - acc_cyc[1][0]), 32'd3);
            chk("lat3_no_bubbles", 32'(pop_cyc[1][7] - pop_cyc[1][0]), 32'd7);
        end

        // RD_LAT=2, DEPTH=200 instance: preload.
        for (int i = 0; i < 8; i++) begin
            wr_en[2] = 1'b1; wr_addr[2] = 8'(pl[i]); wr_data[2] = 16'h2000 + 16'(pl[i]);
            tick();
        end
        wr_en[2] = 1'b0;

        // Backpressure: credit runs out after three accepts, then drain.
        rsp_ready[2] = 1'b0; pop_cyc[2].delete();
        a = 0;
        req_valid[2] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req_addr[2] = 8'(a);
            @(negedge clk);
            if (req_ready[2]) a++;
            tick();
        end
        req_valid[2] = 1'b0;
        @(negedge clk);
        chk("bp_accepts", 32'(a), 32'd3);
        chk("bp_ready_low", 32'(req_ready[2]), 32'd0);
        chk("bp_head", 32'({rsp_valid[2], rsp_instr[2]}), 32'({1'b1, 16'h2000}));
        tick();
        rsp_ready[2] = 1'b1;
        repeat (6) tick();
        chk("bp_drained", 32'(pop_cyc[2].size()), 32'd3);

        // Out of range read and ignored out-of-range write.
        pop_cyc[2].delete();
        wr_en[2] = 1'b1; wr_addr[2] = 8'd250; wr_data[2] = 16'h1234;
        req_valid[2] = 1'b1; req_addr[2] = 8'd250;
        tick();
        wr_en[2] = 1'b0;
        req_addr[2] = 8'd50;  tick();
        req_addr[2] = 8'd122; tick();
        req_addr[2] = 8'd250; tick();
        req_valid[2] = 1'b0;
        repeat (6) tick();
        chk("oor_responses", 32'(pop_cyc[2].size()), 32'd4);

        // Write-first collision.
        wr_en[2] = 1'b1; wr_addr[2] = 8'd9; wr_data[2] = 16'hBEEF;
        req_valid[2] = 1'b1; req_addr[2] = 8'd9;
        tick();
        wr_en[2] = 1'b0; req_valid[2] = 1'b0;
        repeat (4) tick();

        // Flush with three in flight; only the concurrent request survives.
        rsp_ready[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_valid[2] = 1'b1; req_addr[2] = 8'(i);
            tick();
        end
        pop_cyc[2].delete();
        flush[2] = 1'b1; req_addr[2] = 8'd8;
        tick();
        flush[2] = 1'b0; req_valid[2] = 1'b0;
        @(negedge clk);
        chk("flush_rsp_valid", 32'(rsp_valid[2]), 32'd0);
        chk("flush_req_ready", 32'(req_ready[2]), 32'd1);
        tick();
        rsp_ready[2] = 1'b1;
        repeat (8) tick();
        chk("flush_responses", 32'(pop_cyc[2].size()), 32'd1);

        // Asynchronous reset mid-stream, then a cold-start fetch.
        req_valid[2] = 1'b1; req_addr[2] = 8'd0; tick();
        req_addr[2] = 8'd1; tick();
        req_addr[2] = 8'd2;
        chk("rst_pre_valid", 32'(rsp_valid[2]), 32'd1);
        #2 rst_n = 1'b0; req_valid[2] = 1'b0;
        #1;
        chk("rst_mid_rsp_valid", 32'(rsp_valid[2]), 32'd0);
        chk("rst_mid_req_ready", 32'(req_ready[2]), 32'd1);
        #3 rst_n = 1'b1;
        tick();
        pop_cyc[2].delete(); acc_cyc[2].delete();
        req_valid[2] = 1'b1; req_addr[2] = 8'd3;
        tick();
        req_valid[2] = 1'b0;
        repeat (6) tick();
        chk("cold_responses", 32'(pop_cyc[2].size()), 32'd1);
        if (pop_cyc[2].size() == 1 && acc_cyc[2].size() == 1) begin
            chk("cold_latency", 32'(pop_cyc[2][0] - acc_cyc[2][0]), 32'd2);
        end

        repeat (4) tick();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("sb_empty%0d", k), 32'(exp_q[k].size()), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
